// File: rtl/sseg_pkg.sv
// Shared constants and state encodings for the seven-segment driver command sequencer.
package sseg_pkg;

   localparam int WORD_W      = 16;
   localparam int INIT_WORDS  = 5;
   localparam int FRAME_WORDS = 8;

   localparam logic [3:0] DECODE = 4'h9;
   localparam logic [3:0] INTENS = 4'hA;
   localparam logic [3:0] SCANL  = 4'hB;
   localparam logic [3:0] SHDN   = 4'hC;
   localparam logic [3:0] TEST   = 4'hF;

   typedef enum logic [1:0] {INIT, IDLE, FRAME, INTS} ctrl_state_t;
   typedef enum logic [1:0] {TX_IDLE, TX_SHIFT, TX_GAP} tx_state_t;

   function automatic logic [WORD_W-1:0] make_word(input logic [3:0] addr, input logic [7:0] data);
      return {4'h0, addr, data};
   endfunction

endpackage

// File: rtl/sseg_spi_tx.sv
// Shifts one 16-bit word out MSB first: sclk high then low per bit, load held low
// across the word and high for a CLK_DIV-cycle gap afterwards.
module sseg_spi_tx
   import sseg_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [WORD_W-1:0] word,
   output logic              rdy,
   output logic              done,
   output logic              sclk,
   output logic              load,
   output logic              sdo
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

   tx_state_t         state;
   tx_state_t         state_nxt;
   logic [CW-1:0]     cnt;
   logic [3:0]        bit_cnt;
   logic              high;
   logic [WORD_W-1:0] shreg;
   logic              cnt_last;
   logic              accept;

   // The final gap cycle doubles as idle so consecutive words run back to back.
   assign cnt_last = (cnt == CNT_LAST);
   assign done     = (state == TX_GAP) && cnt_last;
   assign rdy      = (state == TX_IDLE) || done;
   assign accept   = start && rdy;

   always_ff @(posedge clk) begin
      if (!rst) state <= TX_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         TX_IDLE:  if (start) state_nxt = TX_SHIFT;
         TX_SHIFT: if (cnt_last && !high && bit_cnt == 4'd0) state_nxt = TX_GAP;
         TX_GAP:   if (cnt_last) state_nxt = start ? TX_SHIFT : TX_IDLE;
         default:  state_nxt = TX_IDLE;
      endcase
   end

   // sdo advances on the falling sclk transition so it is stable across each high phase.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt     <= '0;
         bit_cnt <= '0;
         high    <= 1'b0;
         shreg   <= '0;
         sclk    <= 1'b0;
         load    <= 1'b1;
         sdo     <= 1'b0;
      end else if (accept) begin
         shreg   <= {word[WORD_W-2:0], 1'b0};
         sdo     <= word[WORD_W-1];
         sclk    <= 1'b1;
         load    <= 1'b0;
         high    <= 1'b1;
         cnt     <= '0;
         bit_cnt <= 4'(WORD_W - 1);
      end else if (state != TX_IDLE) begin
         if (!cnt_last) begin
            cnt <= cnt + 1'b1;
         end else begin
            cnt <= '0;
            if (state == TX_SHIFT) begin
               if (high) begin
                  sclk  <= 1'b0;
                  high  <= 1'b0;
                  sdo   <= shreg[WORD_W-1];
                  shreg <= {shreg[WORD_W-2:0], 1'b0};
               end else if (bit_cnt == 4'd0) begin
                  load <= 1'b1;
               end else begin
                  sclk    <= 1'b1;
                  high    <= 1'b1;
                  bit_cnt <= bit_cnt - 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: rtl/sseg_ctrl.sv
// Command sequencer for a MAX7219-style display chain: init sequence, then digit
// frames and intensity updates serialised through sseg_spi_tx.
module sseg_ctrl
   import sseg_pkg::*;
#(
   parameter int         CLK_DIV       = 4,
   parameter logic [3:0] INTENSITY_RST = 4'h8,
   parameter logic [2:0] SCAN_LIMIT    = 3'h7
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [63:0] seg,
   input  logic        seg_vld,
   input  logic        int_up,
   input  logic        int_dn,
   output logic [3:0]  intensity,
   output logic        ready,
   output logic        busy,
   output logic        sclk,
   output logic        load,
   output logic        sdo
);

   ctrl_state_t       state;
   ctrl_state_t       state_nxt;
   logic [3:0]        idx;
   logic [3:0]        n_words;
   logic [63:0]       snapshot;
   logic [63:0]       shadow;
   logic [63:0]       seg_sh;
   logic              frm_pend;
   logic              int_pend;
   logic              tx_start;
   logic              tx_rdy;
   logic              tx_done;
   logic [WORD_W-1:0] tx_word;
   logic              accept;
   logic              up_ok;
   logic              dn_ok;

   assign accept = tx_start && tx_rdy;
   assign up_ok  = int_up && !int_dn && (intensity != 4'hF);
   assign dn_ok  = int_dn && !int_up && (intensity != 4'h0);
   assign seg_sh = snapshot << {idx[2:0], 3'b000};

   always_ff @(posedge clk) begin
      if (!rst) state <= INIT;
      else      state <= state_nxt;
   end

   // idx counts words handed to the transmitter; a state is left once its last word is done.
   always_comb begin
      state_nxt = state;
      tx_start  = 1'b0;
      tx_word   = '0;
      n_words   = 4'd0;
      busy      = 1'b1;
      case (state)
         INIT: begin
            n_words = 4'(INIT_WORDS);
            case (idx)
               4'd0:    tx_word = make_word(DECODE, 8'h00);
               4'd1:    tx_word = make_word(SCANL, {5'h00, SCAN_LIMIT});
               4'd2:    tx_word = make_word(INTENS, {4'h0, intensity});
               4'd3:    tx_word = make_word(TEST, 8'h00);
               default: tx_word = make_word(SHDN, 8'h01);
            endcase
         end
         FRAME: begin
            n_words = 4'(FRAME_WORDS);
            tx_word = make_word(idx + 4'd1, seg_sh[63:56]);
         end
         INTS: begin
            n_words = 4'd1;
            tx_word = make_word(INTENS, {4'h0, intensity});
         end
         default: begin
            busy = int_pend || frm_pend;
            if (int_pend)      state_nxt = INTS;
            else if (frm_pend) state_nxt = FRAME;
         end
      endcase
      if (state != IDLE) begin
         tx_start = (idx < n_words);
         if (tx_done && idx == n_words) state_nxt = IDLE;
      end
   end

   // A seg_vld during FRAME only reaches the shadow; the frame on the wire stays coherent.
   always_ff @(posedge clk) begin
      if (!rst) begin
         idx       <= '0;
         ready     <= 1'b0;
         intensity <= INTENSITY_RST;
         int_pend  <= 1'b0;
         frm_pend  <= 1'b0;
         snapshot  <= '0;
         shadow    <= '0;
      end else begin
         if (state_nxt != state) idx <= '0;
         else if (accept)        idx <= idx + 4'd1;

         if (state == INIT && state_nxt == IDLE) ready <= 1'b1;

         if (up_ok)      intensity <= intensity + 4'd1;
         else if (dn_ok) intensity <= intensity - 4'd1;

         if (state_nxt == INTS && state != INTS) int_pend <= 1'b0;
         else if (up_ok || dn_ok)                int_pend <= 1'b1;

         if (seg_vld) shadow <= seg;

         if (state_nxt == FRAME && state != FRAME) begin
            snapshot <= seg_vld ? seg : shadow;
            frm_pend <= 1'b0;
         end else if (seg_vld) begin
            frm_pend <= 1'b1;
            if (state != FRAME) snapshot <= seg;
         end
      end
   end

   sseg_spi_tx #(
      .CLK_DIV (CLK_DIV)
   ) u_tx (
      .clk   (clk),
      .rst   (rst),
      .start (tx_start),
      .word  (tx_word),
      .rdy   (tx_rdy),
      .done  (tx_done),
      .sclk  (sclk),
      .load  (load),
      .sdo   (sdo)
   );

endmodule

// File: tb/tb_sseg_ctrl.sv
// Directed bench for sseg_ctrl: a serial monitor decodes words on sclk rise and
// latches them when load rises, and each scenario checks the decoded word stream.
module tb_sseg_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] seg;
   logic        seg_vld;
   logic        int_up;
   logic        int_dn;
   logic [3:0]  intensity;
   logic        ready;
   logic        busy;
   logic        sclk;
   logic        load;
   logic        sdo;

   int          compared   = 0;
   int          mismatched = 0;

   logic [15:0] words[$];
   logic [15:0] mon_sh;
   int          bits_seen = 0;
   logic        sclk_q = 1'b0;
   logic        load_q = 1'b1;

   sseg_ctrl #(
      .CLK_DIV       (2),
      .INTENSITY_RST (4'h8),
      .SCAN_LIMIT    (3'h7)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .seg       (seg),
      .seg_vld   (seg_vld),
      .int_up    (int_up),
      .int_dn    (int_dn),
      .intensity (intensity),
      .ready     (ready),
      .busy      (busy),
      .sclk      (sclk),
      .load      (load),
      .sdo       (sdo)
   );

   always #5 clk = ~clk;

   // Aborted words (load rising before 16 bits) are dropped.
   always @(negedge clk) begin
      if (!rst) begin
         bits_seen = 0;
      end else begin
         if (sclk && !sclk_q) begin
            mon_sh    = {mon_sh[14:0], sdo};
            bits_seen = bits_seen + 1;
         end
         if (load && !load_q) begin
            if (bits_seen == 16) words.push_back(mon_sh);
            bits_seen = 0;
         end
      end
      sclk_q = sclk;
      load_q = load;
   end

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      if (obs !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic vld, input logic [63:0] s, input logic up, input logic dn);
      @(negedge clk);
      seg     = s;
      seg_vld = vld;
      int_up  = up;
      int_dn  = dn;
      @(negedge clk);
      seg_vld = 1'b0;
      int_up  = 1'b0;
      int_dn  = 1'b0;
   endtask

   task automatic waitIdle(input int budget, input string tag);
      int n;
      n = 0;
      while (busy !== 1'b0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      checkOutput(tag, 64'(busy), 64'h0);
   endtask

   task automatic waitReady(input int budget, output int cycles);
      cycles = 0;
      do begin
         @(negedge clk);
         cycles++;
      end while (ready !== 1'b1 && cycles < budget);
   endtask

   function automatic logic [15:0] getWord(input int i);
      if (i < words.size()) return words[i];
      return 16'hFFFF;
   endfunction

   function automatic logic [15:0] frameWord(input logic [63:0] s, input int i);
      logic [63:0] t;
      t = s >> (8 * (7 - i));
      return {4'h0, 4'(i + 1), t[7:0]};
   endfunction

   logic [15:0] init_exp[5] = '{16'h0900, 16'h0B07, 16'h0A08, 16'h0F00, 16'h0C01};
   logic [63:0] seg_a = 64'h7e306d79335b5f70;
   logic [63:0] seg_c = 64'h0102030405060708;
   logic [63:0] seg_x = 64'h1122334455667788;
   logic [63:0] seg_y = 64'hAAAAAAAAAAAAAAAA;
   logic [63:0] seg_b = 64'h0F1E2D3C4B5A6978;

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int cyc;
      rst     = 1'b0;
      seg     = '0;
      seg_vld = 1'b0;
      int_up  = 1'b0;
      int_dn  = 1'b0;

      // Reset values and init sequence.
      repeat (3) @(negedge clk);
      checkOutput("rst_sclk", 64'(sclk), 64'h0);
      checkOutput("rst_load", 64'(load), 64'h1);
      checkOutput("rst_sdo", 64'(sdo), 64'h0);
      checkOutput("rst_ready", 64'(ready), 64'h0);
      checkOutput("rst_busy", 64'(busy), 64'h1);
      checkOutput("rst_intensity", 64'(intensity), 64'h8);
      rst = 1'b1;
      waitReady(400, cyc);
      checkOutput("init_ready_cycles", 64'(cyc - 1), 64'd330);
      checkOutput("init_busy", 64'(busy), 64'h0);
      checkOutput("init_count", 64'(words.size()), 64'd5);
      for (int i = 0; i < 5; i++) checkOutput($sformatf("init_w%0d", i), 64'(getWord(i)), 64'(init_exp[i]));

      // Single frame.
      words.delete();
      applyStimulus(1'b1, seg_a, 1'b0, 1'b0);
      waitIdle(1000, "frame_idle");
      checkOutput("frame_count", 64'(words.size()), 64'd8);
      for (int i = 0; i < 8; i++) checkOutput($sformatf("frame_w%0d", i), 64'(getWord(i)), 64'(frameWord(seg_a, i)));

      // Intensity request wins over a simultaneous frame request.
      words.delete();
      applyStimulus(1'b1, seg_c, 1'b1, 1'b0);
      waitIdle(1200, "prio_idle");
      checkOutput("prio_count", 64'(words.size()), 64'd9);
      checkOutput("prio_first", 64'(getWord(0)), 64'h0A09);
      for (int i = 0; i < 8; i++) checkOutput($sformatf("prio_w%0d", i), 64'(getWord(i + 1)), 64'(frameWord(seg_c, i)));

      // Saturation at 15 and 0, ignored pulses, and the up+down no-op.
      words.delete();
      for (int i = 0; i < 10; i++) applyStimulus(1'b0, seg, 1'b1, 1'b0);
      waitIdle(1000, "sat_hi_idle");
      checkOutput("sat_hi_value", 64'(intensity), 64'hF);
      checkOutput("sat_hi_last", 64'(getWord(int'(words.size()) - 1)), 64'h0A0F);
      words.delete();
      applyStimulus(1'b0, seg, 1'b1, 1'b0);
      repeat (20) @(negedge clk);
      checkOutput("sat_hi_noword", 64'(words.size()), 64'd0);
      checkOutput("sat_hi_busy", 64'(busy), 64'h0);
      applyStimulus(1'b0, seg, 1'b1, 1'b1);
      repeat (20) @(negedge clk);
      checkOutput("updn_value", 64'(intensity), 64'hF);
      checkOutput("updn_noword", 64'(words.size()), 64'd0);
      for (int i = 0; i < 16; i++) applyStimulus(1'b0, seg, 1'b0, 1'b1);
      waitIdle(1000, "sat_lo_idle");
      checkOutput("sat_lo_value", 64'(intensity), 64'h0);
      checkOutput("sat_lo_last", 64'(getWord(int'(words.size()) - 1)), 64'h0A00);
      words.delete();
      applyStimulus(1'b0, seg, 1'b0, 1'b1);
      repeat (20) @(negedge clk);
      checkOutput("sat_lo_noword", 64'(words.size()), 64'd0);

      // Two requests during one frame coalesce into a single follow-up frame.
      words.delete();
      applyStimulus(1'b1, seg_x, 1'b0, 1'b0);
      repeat (100) @(negedge clk);
      applyStimulus(1'b1, seg_y, 1'b0, 1'b0);
      repeat (50) @(negedge clk);
      applyStimulus(1'b1, seg_b, 1'b0, 1'b0);
      waitIdle(2000, "coal_idle");
      checkOutput("coal_count", 64'(words.size()), 64'd16);
      for (int i = 0; i < 8; i++) begin
         checkOutput($sformatf("coal_x%0d", i), 64'(getWord(i)), 64'(frameWord(seg_x, i)));
         checkOutput($sformatf("coal_b%0d", i), 64'(getWord(i + 8)), 64'(frameWord(seg_b, i)));
      end

      // Reset mid-word aborts it and restarts the init sequence.
      words.delete();
      applyStimulus(1'b1, seg_a, 1'b0, 1'b0);
      cyc = 0;
      while (bits_seen != 9 && cyc < 2000) begin
         @(negedge clk);
         cyc++;
      end
      checkOutput("mid_reach_bit7", 64'(bits_seen), 64'd9);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("mid_sclk", 64'(sclk), 64'h0);
      checkOutput("mid_load", 64'(load), 64'h1);
      checkOutput("mid_sdo", 64'(sdo), 64'h0);
      checkOutput("mid_ready", 64'(ready), 64'h0);
      checkOutput("mid_intensity", 64'(intensity), 64'h8);
      repeat (2) @(negedge clk);
      words.delete();
      rst = 1'b1;
      waitReady(400, cyc);
      checkOutput("reinit_ready_cycles", 64'(cyc - 1), 64'd330);
      checkOutput("reinit_count", 64'(words.size()), 64'd5);
      checkOutput("reinit_first", 64'(getWord(0)), 64'h0900);
      checkOutput("reinit_intens", 64'(getWord(2)), 64'h0A08);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
